mux_gate_bitserial_unit: RTL

Bit-serial logic stage that consumes the team's 1-bit MUX-based gates. It accepts a WIDTH-bit operand pair and an opcode over a valid/ready handshake. It evaluates one bit per clock through a single MUX-gate slice and returns the WIDTH-bit result over a second valid/ready handshake. It is the sequential consumer of the MUX-based AND/OR/XOR gates, trading area for WIDTH cycles of latency.

---
 rtl/mux_gate_pkg.sv | 15 +
 rtl/and_using_mux.sv | 8 +
 rtl/mux_gate_slice.sv | 19 +
 rtl/or_using_mux.sv | 8 +
 rtl/xor_using_mux.sv | 8 +
 rtl/mux_gate_bitserial_unit.sv | 87 ++++++++
 6 files changed

// File: rtl/mux_gate_pkg.sv
// Shared opcode and state encodings for the MUX-gate datapath and its bit-serial consumer.
package mux_gate_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/and_using_mux.sv
// 1-bit AND built from a single 2:1 selection.
module and_using_mux (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ? b : 1'b0;
endmodule

// File: rtl/mux_gate_slice.sv
// One-bit logic slice: evaluates AND/OR/XOR/XNOR of a bit pair using only 2:1 selections.
module mux_gate_slice (
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic [1:0] op,
    output logic       y_bit
);
    logic y_and, y_or, y_xor, y_xnor;

    and_using_mux u_and (.a(a_bit), .b(b_bit), .y(y_and));
    or_using_mux  u_or  (.a(a_bit), .b(b_bit), .y(y_or));
    xor_using_mux u_xor (.a(a_bit), .b(b_bit), .y(y_xor));

    // XNOR is the XOR mux with its data inputs swapped
    assign y_xnor = a_bit ? b_bit : ~b_bit;

    assign y_bit = op[1] ? (op[0] ? y_xnor : y_xor)
                         : (op[0] ? y_or   : y_and);
endmodule

// File: rtl/or_using_mux.sv
// 1-bit OR built from a single 2:1 selection.
module or_using_mux (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ? 1'b1 : b;
endmodule

// File: rtl/xor_using_mux.sv
// 1-bit XOR built from a single 2:1 selection.
module xor_using_mux (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ? ~b : b;
endmodule

// File: rtl/mux_gate_bitserial_unit.sv
// Bit-serial logic unit: captures an operand pair, evaluates one bit per clock through
// a single mux_gate_slice, and returns the WIDTH-bit result over a valid/ready handshake.
module mux_gate_bitserial_unit
    import mux_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, y_sh, y_next;
    logic [1:0]       op_q;
    logic             bit_y;

    mux_gate_slice u_slice (
        .a_bit(a_sh[0]),
        .b_bit(b_sh[0]),
        .op   (op_q),
        .y_bit(bit_y)
    );

    // New bit enters at the MSB; the wide shift keeps WIDTH=1 legal without a special case
    assign y_next = WIDTH'({bit_y, y_sh} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            y_sh      <= '0;
            op_q      <= OP_AND;
            y         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_q     <= op;
                        y_sh     <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    y_sh <= y_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        y         <= y_next;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
